// File: rtl/dec_nx2n_bist.sv
// Registered N-to-2^N one-hot decoder with a single-line stuck-at fault injector and a BIST sweep.
// Define DEC_FAULT_INJ_EN to build the fault register; without it the decoder output is never forced.
module dec_nx2n_bist #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   a,
  output logic [2**N-1:0] d,
  input  logic           fault_we,
  input  logic           fault_on,
  input  logic [N-1:0]   fault_idx,
  input  logic           fault_val,
  input  logic           bist_start,
  output logic           bist_busy,
  output logic           bist_done,
  output logic           bist_pass,
  output logic [N:0]     err_cnt,
  output logic [N-1:0]   first_err
);

  localparam int W = 2**N;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [N:0] LAST = (N+1)'(W-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N:0]     cnt;
  logic           first_seen;
  logic [W-1:0]   raw_run, raw_norm, fault_run, fault_norm;
  logic           mismatch;
  logic [N:0]     err_nxt;
  logic           cfg_ok;

  assign cfg_ok = (state == IDLE) || (state == DONE);

`ifdef DEC_FAULT_INJ_EN
  logic           fault_on_r;
  logic [N-1:0]   fault_idx_r;
  logic           fault_val_r;

  // Writes while the sweep runs are dropped, so a sweep always sees one fixed fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_on_r  <= 1'b0;
      fault_idx_r <= '0;
      fault_val_r <= 1'b0;
    end else if (fault_we && cfg_ok) begin
      fault_on_r  <= fault_on;
      fault_idx_r <= fault_idx;
      fault_val_r <= fault_val;
    end
  end
`else
  logic unused_fault;
  assign unused_fault = &{1'b0, fault_we, fault_on, fault_idx, fault_val};
`endif

  // The force is applied after enable gating, so a stuck-at-1 shows even with en low.
  always_comb begin
    raw_run    = ONE << cnt[N-1:0];
    raw_norm   = en ? (ONE << a) : '0;
    fault_run  = raw_run;
    fault_norm = raw_norm;
`ifdef DEC_FAULT_INJ_EN
    if (fault_on_r) begin
      fault_run[fault_idx_r]  = fault_val_r;
      fault_norm[fault_idx_r] = fault_val_r;
    end
`endif
    mismatch = (fault_run != raw_run);
    err_nxt  = err_cnt + {{N{1'b0}}, mismatch};
  end

  // Handshake: bist_start is a level sampled only in IDLE; bist_busy is high for the
  // whole sweep, then bist_done pulses for one cycle with results already valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      first_seen <= 1'b0;
      d          <= '0;
      bist_busy  <= 1'b0;
      bist_done  <= 1'b0;
      bist_pass  <= 1'b0;
      err_cnt    <= '0;
      first_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bist_done <= 1'b0;
          if (bist_start) begin
            state      <= RUN;
            cnt        <= '0;
            err_cnt    <= '0;
            first_err  <= '0;
            bist_pass  <= 1'b0;
            first_seen <= 1'b1;
            bist_busy  <= 1'b1;
            d          <= '0;
          end else begin
            d <= fault_norm;
          end
        end
        RUN: begin
          d       <= '0;
          err_cnt <= err_nxt;
          if (mismatch && first_seen) begin
            first_err  <= cnt[N-1:0];
            first_seen <= 1'b0;
          end
          cnt <= cnt + (N+1)'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= (err_nxt == '0);
          end
        end
        DONE: begin
          bist_done <= 1'b0;
          d         <= fault_norm;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bist_busy <= 1'b0;
          bist_done <= 1'b0;
          d         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_nx2n_bist.sv
// Self-checking bench for dec_nx2n_bist (N=4): directed plan plus randomized faults and decodes.
module tb_dec_nx2n_bist;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   a;
  logic [W-1:0]   d;
  logic           fault_we, fault_on, fault_val;
  logic [N-1:0]   fault_idx;
  logic           bist_start;
  logic           bist_busy, bist_done, bist_pass;
  logic [N:0]     err_cnt;
  logic [N-1:0]   first_err;

  dec_nx2n_bist #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .d(d),
    .fault_we(fault_we), .fault_on(fault_on), .fault_idx(fault_idx), .fault_val(fault_val),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .err_cnt(err_cnt), .first_err(first_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference state: what the fault register should hold
  logic           m_on = 1'b0;
  logic [N-1:0]   m_idx = '0;
  logic           m_val = 1'b0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_force(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef DEC_FAULT_INJ_EN
    if (m_on) r[m_idx] = m_val;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] model_dec(input logic [N-1:0] code, input logic e);
    logic [W-1:0] v;
    v = '0;
    if (e) v[code] = 1'b1;
    return model_force(v);
  endfunction

  task automatic model_bist(output logic [N:0] e, output logic [N-1:0] f, output logic p);
    logic [W-1:0] golden;
    e = '0;
    f = '0;
    for (int c = 0; c < W; c++) begin
      golden = '0;
      golden[c] = 1'b1;
      if (model_force(golden) !== golden) begin
        if (e == 0) f = N'(c);
        e = e + 1'b1;
      end
    end
    p = (e == 0);
  endtask

  // drivers
  task automatic decode(input logic [N-1:0] code, input logic e);
    a  = code;
    en = e;
    exp_q.push_back(model_dec(code, e));
    tick;
    chk("d", d, exp_q.pop_front());
  endtask

  task automatic program_fault(input logic on, input logic [N-1:0] idx, input logic val);
    fault_we  = 1'b1;
    fault_on  = on;
    fault_idx = idx;
    fault_val = val;
    tick;
    fault_we = 1'b0;
    m_on  = on;
    m_idx = idx;
    m_val = val;
  endtask

  task automatic run_bist(input bit disturb);
    logic [N:0]   ee;
    logic [N-1:0] ff;
    logic         pp;
    int cyc, busy_n;
    bit done_seen;
    model_bist(ee, ff, pp);
    cyc = 0;
    busy_n = 0;
    done_seen = 0;
    bist_start = 1'b1;
    while (cyc < 40 && !done_seen) begin
      tick;
      cyc++;
      if (bist_busy) begin
        busy_n++;
        chk("run_d_zero", d, '0);
      end
      if (bist_done) done_seen = 1;
      else if (disturb) begin
        bist_start = 1'($urandom_range(0, 1));
        fault_we   = 1'b1;
        fault_on   = 1'($urandom);
        fault_idx  = N'($urandom);
        fault_val  = 1'($urandom);
        a          = N'($urandom);
        en         = 1'b1;
      end else begin
        bist_start = 1'b0;
      end
    end
    bist_start = 1'b0;
    fault_we   = 1'b0;
    chk("done_seen", 32'(done_seen), 1);
    chk("done_latency", cyc, 17);
    chk("busy_cycles", busy_n, 16);
    chk("busy_at_done", bist_busy, 0);
    chk("err_cnt", err_cnt, ee);
    chk("first_err", first_err, ff);
    chk("bist_pass", bist_pass, pp);
    tick;
    chk("done_one_cycle", bist_done, 0);
    chk("err_cnt_hold", err_cnt, ee);
    chk("pass_hold", bist_pass, pp);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; en = 1'b0; a = '0; fault_we = 1'b0; fault_on = 1'b0;
    fault_idx = '0; fault_val = 1'b0; bist_start = 1'b0;
    tick;
    tick;
    chk("rst_d", d, 0);
    chk("rst_busy", bist_busy, 0);
    chk("rst_done", bist_done, 0);
    chk("rst_pass", bist_pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_first", first_err, 0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < W; i++) decode(N'(i), 1'b1);
    decode(4'd5, 1'b0);

    program_fault(1'b1, 4'd8, 1'b0);
    decode(4'd8, 1'b1);
    decode(4'd9, 1'b1);
    program_fault(1'b1, 4'd3, 1'b1);
    decode(4'd0, 1'b0);
    run_bist(0);
    program_fault(1'b1, 4'd8, 1'b0);
    run_bist(0);
    program_fault(1'b0, 4'd0, 1'b0);
    run_bist(0);

    for (int r = 0; r < 8; r++) begin
      program_fault(1'($urandom), N'($urandom), 1'($urandom));
      for (int k = 0; k < 6; k++) decode(N'($urandom), 1'($urandom_range(0, 3) != 0));
      run_bist(0);
    end

    // inputs toggled during the sweep must neither restart it nor touch the fault register
    program_fault(1'b1, 4'd5, 1'b1);
    run_bist(1);
    decode(4'd2, 1'b0);
    decode(4'd5, 1'b1);

    // reset in the middle of a sweep
    bist_start = 1'b1;
    tick;
    bist_start = 1'b0;
    repeat (5) tick;
    chk("mid_busy", bist_busy, 1);
    rst_n = 1'b0;
    #1;
    m_on = 1'b0; m_idx = '0; m_val = 1'b0;
    chk("arst_d", d, 0);
    chk("arst_busy", bist_busy, 0);
    chk("arst_done", bist_done, 0);
    chk("arst_pass", bist_pass, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_first", first_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bist_done) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", bist_busy, 0);
    decode(4'd5, 1'b0);
    decode(4'd7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
